// File: rtl/adder_csel_pipe.sv
// rtl/adder_csel_pipe.sv - two-stage pipelined carry-select adder/subtractor
// Stage 1 forms per-block candidate sums; stage 2 resolves the block carry chain.
module adder_csel_pipe #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NBLK = WIDTH / BLOCK;

  if (WIDTH < 2 || BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_params
    $error("adder_csel_pipe: WIDTH must be >= 2 and a multiple of BLOCK");
  end

  logic             en;
  logic [WIDTH-1:0] bx;
  logic             c0;
  logic [BLOCK:0]   t0;
  logic [BLOCK:0]   t1;
  logic [BLOCK-1:0] sum0_d [NBLK];
  logic [BLOCK-1:0] sum1_d [NBLK];
  logic             car0_d [NBLK];
  logic             car1_d [NBLK];

  logic             s1_valid;
  logic [BLOCK-1:0] s1_sum0 [NBLK];
  logic [BLOCK-1:0] s1_sum1 [NBLK];
  logic             s1_car0 [NBLK];
  logic             s1_car1 [NBLK];
  logic             s1_amsb;
  logic             s1_bmsb;

  logic [NBLK:0]    c;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Block 0 already knows its real carry-in, so both of its candidates carry
  // the ripple result; stage 2 can then treat every block uniformly.
  always_comb begin
    bx = sub ? ~b : b;
    c0 = sub | cin;
    t0 = '0;
    t1 = '0;
    for (int k = 0; k < NBLK; k++) begin
      t0 = {1'b0, a[k*BLOCK +: BLOCK]} + {1'b0, bx[k*BLOCK +: BLOCK]}
           + {{BLOCK{1'b0}}, (k == 0) ? c0 : 1'b0};
      t1 = {1'b0, a[k*BLOCK +: BLOCK]} + {1'b0, bx[k*BLOCK +: BLOCK]}
           + {{BLOCK{1'b0}}, (k == 0) ? c0 : 1'b1};
      sum0_d[k] = t0[BLOCK-1:0];
      car0_d[k] = t0[BLOCK];
      sum1_d[k] = t1[BLOCK-1:0];
      car1_d[k] = t1[BLOCK];
    end
  end

  always_comb begin
    c     = '0;
    sum_d = '0;
    for (int k = 0; k < NBLK; k++) begin
      sum_d[k*BLOCK +: BLOCK] = c[k] ? s1_sum1[k] : s1_sum0[k];
      c[k+1]                  = c[k] ? s1_car1[k] : s1_car0[k];
    end
    ovf_d = (s1_amsb == s1_bmsb) && (sum_d[WIDTH-1] != s1_amsb);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_sum0   <= sum0_d;
      s1_sum1   <= sum1_d;
      s1_car0   <= car0_d;
      s1_car1   <= car1_d;
      s1_amsb   <= a[WIDTH-1];
      s1_bmsb   <= bx[WIDTH-1];
      out_valid <= s1_valid;
      sum       <= sum_d;
      cout      <= c[NBLK];
      ovf       <= ovf_d;
    end
  end

endmodule
